// File: rtl/rs_syndrome_calc_if.sv
// Handshake bundle between framed-data ingress, the syndrome calculator and the key-equation solver.
// Latency: none; wires only.
// Backpressure: in_ready/synd_ready carry it; slave = syndrome calculator, master = its environment.
// Ports: in_valid/in_ready/in_data/in_last (beat side), synd_valid/synd_ready/synd/synd_zero/len_err (result side).
interface rs_syndrome_calc_if #(
  parameter int LANES = 16,
  parameter int NSYM  = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*8-1:0]    in_data;
  logic                  in_last;
  logic                  synd_valid;
  logic                  synd_ready;
  logic [NSYM*8-1:0]     synd;
  logic                  synd_zero;
  logic                  len_err;

  modport slave (
    input  in_valid, in_data, in_last, synd_ready,
    output in_ready, synd_valid, synd, synd_zero, len_err
  );

  modport master (
    output in_valid, in_data, in_last, synd_ready,
    input  in_ready, synd_valid, synd, synd_zero, len_err
  );
endinterface

// File: rtl/rs_syndrome_calc.sv
// Reed-Solomon syndrome calculator, GF(2^8) poly 0x11D, all NSYM syndromes in parallel, LANES bytes/beat.
// Latency: syndrome set registered, synd_valid rises the cycle after the closing beat is accepted.
// Backpressure: in_ready = !synd_valid | synd_ready; any beat stalls while an unaccepted set is held.
// Ports: clk, rst (async active-high), bus (slave modport): beats in, syndrome set + zero/len_err flags out.
module rs_syndrome_calc #(
  parameter int LANES = 16,
  parameter int NSYM  = 16,
  parameter int FCR   = 1,
  parameter int BEATS = 16
) (
  input  logic               clk,
  input  logic               rst,
  rs_syndrome_calc_if.slave  bus
);

  // GF(2^8) multiply, reduction by x^8+x^4+x^3+x^2+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] r;
    x = a;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) r = r ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return r;
  endfunction

  // alpha^e for 0 <= e < 255 by square-and-multiply.
  function automatic logic [7:0] gf_pow(input int e);
    logic [7:0] r;
    logic [7:0] base;
    r    = 8'h01;
    base = 8'h02;
    for (int i = 0; i < 8; i++) begin
      if (e[i]) r = gf_mul(r, base);
      base = gf_mul(base, base);
    end
    return r;
  endfunction

  localparam logic [7:0] LAST_CNT = 8'(BEATS - 1);

  logic [7:0]                       cnt;
  logic [NSYM-1:0][7:0]             acc;
  // bm[j] = alpha^((cnt*LANES*(FCR+j)) mod 255): weight of lane 0 in the current beat.
  // Stepping it per beat keeps the exponent reduced mod 255 without any runtime modulo.
  logic [NSYM-1:0][7:0]             bm;
  logic [NSYM-1:0][7:0]             step;
  logic [NSYM-1:0][LANES-1:0][7:0]  prod;
  logic [NSYM-1:0][7:0]             beat_sum;
  logic [NSYM-1:0][7:0]             nxt;

  logic [NSYM-1:0][7:0]             synd_q;
  logic                             synd_vld_q;
  logic                             synd_zero_q;
  logic                             len_err_q;

  logic                             accept;
  logic                             at_end;
  logic                             close;

  // Per-lane constants alpha^(k*(FCR+j)) are fixed at elaboration; only bm[j] varies at runtime.
  for (genvar j = 0; j < NSYM; j++) begin : g_syn
    localparam int R = FCR + j;
    assign step[j] = gf_pow((LANES * R) % 255);
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      localparam logic [7:0] LC = gf_pow((k * R) % 255);
      assign prod[j][k] = gf_mul(bus.in_data[k*8 +: 8], LC);
    end
  end

  always_comb begin
    beat_sum = '0;
    nxt      = '0;
    for (int j = 0; j < NSYM; j++) begin
      for (int k = 0; k < LANES; k++) begin
        beat_sum[j] = beat_sum[j] ^ prod[j][k];
      end
      nxt[j] = acc[j] ^ gf_mul(beat_sum[j], bm[j]);
    end
  end

  assign bus.in_ready = ~synd_vld_q | bus.synd_ready;
  assign accept       = bus.in_valid & bus.in_ready;
  assign at_end       = (cnt == LAST_CNT);
  assign close        = accept & (bus.in_last | at_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      acc         <= '0;
      for (int j = 0; j < NSYM; j++) bm[j] <= 8'h01;
      synd_q      <= '0;
      synd_vld_q  <= 1'b0;
      synd_zero_q <= 1'b0;
      len_err_q   <= 1'b0;
    end else begin
      if (synd_vld_q && bus.synd_ready) synd_vld_q <= 1'b0;
      if (close) begin
        synd_q      <= nxt;
        synd_zero_q <= (nxt == '0);
        len_err_q   <= bus.in_last ^ at_end;
        synd_vld_q  <= 1'b1;
        acc         <= '0;
        cnt         <= '0;
        for (int j = 0; j < NSYM; j++) bm[j] <= 8'h01;
      end else if (accept) begin
        acc <= nxt;
        cnt <= cnt + 8'd1;
        for (int j = 0; j < NSYM; j++) bm[j] <= gf_mul(bm[j], step[j]);
      end
    end
  end

  assign bus.synd_valid = synd_vld_q;
  assign bus.synd       = synd_q;
  assign bus.synd_zero  = synd_zero_q;
  assign bus.len_err    = len_err_q;

endmodule
